hm_sha_controller: RTL and testbench

HM_SHA_CONTROLLER -- requirements
Module: hm_sha_controller

---
 rtl/hm_ctrl_pkg.sv | 29 ++
 rtl/hm_round_counter.sv | 47 ++++
 rtl/hm_sha_controller.sv | 156 +++++++++++++++
 tb/tb_hm_sha_controller.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hm_ctrl_pkg.sv
// ============================================================================
// Module      : hm_ctrl_pkg
// Description : Shared types and constants for the double-SHA controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hm_ctrl_pkg;

    localparam int ROUNDS = 64;
    localparam int CNT_W  = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_LOAD  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        PASS_BLK1 = 2'b00,
        PASS_BLK2 = 2'b01,
        PASS_DBL  = 2'b10
    } pass_e;

endpackage

`default_nettype wire

// File: rtl/hm_round_counter.sv
// ============================================================================
// Module      : hm_round_counter
// Description : Saturating round counter with enable, clear and last flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hm_round_counter
    import hm_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(ROUNDS - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear wins over enable; the counter holds at the last round rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != LAST_VAL)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == LAST_VAL);

endmodule

`default_nettype wire

// File: rtl/hm_sha_controller.sv
// ============================================================================
// Module      : hm_sha_controller
// Description : Sequences a SHA-256 core through the three passes of a double
//               hash. Optional HM_CTRL_AUTO_RESTART_EN adds auto_run/nonce_inc.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hm_sha_controller
    import hm_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
`ifdef HM_CTRL_AUTO_RESTART_EN
    input  logic             auto_run,
    output logic             nonce_inc,
`endif
    output logic [CNT_W-1:0] count,
    output logic             init,
    output logic             halt,
    output logic             clear,
    output logic             out_load,
    output logic [1:0]       hash_select,
    output logic             busy,
    output logic             done
);

    state_e state_q, state_d;
    pass_e  pass_q,  pass_d;
    logic   init_q,  init_d;
    logic   halt_q,  halt_d;
    logic   clear_q, clear_d;
    logic   load_q,  load_d;
    logic   busy_q,  busy_d;
    logic   done_q,  done_d;
    logic   auto_q,  auto_d;
    logic   w_auto;
    logic   w_last;
    logic   w_cnt_en;
    logic   w_cnt_clr;
    logic   w_in_pass;

`ifdef HM_CTRL_AUTO_RESTART_EN
    assign w_auto    = auto_run;
    assign nonce_inc = auto_q;
`else
    assign w_auto    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        if (abort) begin
            state_d = ST_IDLE;
            pass_d  = PASS_BLK1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_INIT;
                        pass_d  = PASS_BLK1;
                    end
                end
                ST_INIT:  state_d = ST_ROUND;
                ST_ROUND: begin
                    if (!pause && w_last) begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    case (pass_q)
                        PASS_BLK1: begin
                            state_d = ST_INIT;
                            pass_d  = PASS_BLK2;
                        end
                        PASS_BLK2: begin
                            state_d = ST_INIT;
                            pass_d  = PASS_DBL;
                        end
                        default:   state_d = ST_DONE;
                    endcase
                end
                ST_DONE: begin
                    // auto_q was captured on entry to DONE so busy, nonce_inc and the restart agree.
                    state_d = auto_q ? ST_INIT : ST_IDLE;
                    pass_d  = PASS_BLK1;
                end
                default: begin
                    state_d = ST_IDLE;
                    pass_d  = PASS_BLK1;
                end
            endcase
        end
    end

    always_comb begin
        w_in_pass = (state_d == ST_INIT) || (state_d == ST_ROUND) || (state_d == ST_LOAD);
        init_d    = (state_d == ST_INIT);
        halt_d    = !((state_d == ST_INIT) ||
                      ((state_d == ST_ROUND) && !((state_q == ST_ROUND) && pause)));
        clear_d   = w_in_pass && (pass_d != PASS_BLK2);
        load_d    = (state_d == ST_LOAD);
        done_d    = (state_d == ST_DONE);
        auto_d    = (state_d == ST_DONE) && w_auto;
        busy_d    = w_in_pass || auto_d;
        w_cnt_clr = (state_d != ST_ROUND);
        w_cnt_en  = (state_q == ST_ROUND) && (state_d == ST_ROUND) && !pause;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pass_q  <= PASS_BLK1;
            init_q  <= 1'b0;
            halt_q  <= 1'b1;
            clear_q <= 1'b0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            auto_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            init_q  <= init_d;
            halt_q  <= halt_d;
            clear_q <= clear_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            auto_q  <= auto_d;
        end
    end

    hm_round_counter u_round_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (w_cnt_en),
        .clr   (w_cnt_clr),
        .count (count),
        .last  (w_last)
    );

    assign init        = init_q;
    assign halt        = halt_q;
    assign clear       = clear_q;
    assign out_load    = load_q;
    assign hash_select = pass_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_hm_sha_controller.sv
// ============================================================================
// Module      : tb_hm_sha_controller
// Description : Self-checking bench for hm_sha_controller (event scoreboard
//               plus a table of per-cycle output probes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hm_sha_controller;

    typedef struct {
        int         cyc;
        int         kind;   // 0 init, 1 out_load, 2 done
        logic [1:0] hs;
        logic       clr;
        logic       bsy;
        logic       nin;
    } ev_t;

    typedef struct {
        int         k;
        int         cnt;    // -1 = not checked
        logic       halt;
        logic       init;
        logic       ld;
        logic       clr;
        logic       bsy;
        logic [1:0] hs;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       pause;
    logic [6:0] count;
    logic       init;
    logic       halt;
    logic       clear;
    logic       out_load;
    logic [1:0] hash_select;
    logic       busy;
    logic       done;
`ifdef HM_CTRL_AUTO_RESTART_EN
    logic       auto_run;
    logic       nonce_inc;
`endif

    int   n_chk;
    int   n_fail;
    ev_t  exp_q[$];
    vec_t tbl[12];

    hm_sha_controller dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .pause       (pause),
`ifdef HM_CTRL_AUTO_RESTART_EN
        .auto_run    (auto_run),
        .nonce_inc   (nonce_inc),
`endif
        .count       (count),
        .init        (init),
        .halt        (halt),
        .clear       (clear),
        .out_load    (out_load),
        .hash_select (hash_select),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Queue the strobe events of one job; events at offset >= sh_from move by sh,
    // and only events with offset < lim are expected (job cut short).
    task automatic push_job(input int base, input int sh_from, input int sh,
                            input int lim, input bit auto_b);
        int         offs[7];
        int         kinds[7];
        logic [1:0] hss[7];
        ev_t        e;
        offs  = '{1, 66, 67, 132, 133, 198, 199};
        kinds = '{0, 1, 0, 1, 0, 1, 2};
        hss   = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
        for (int i = 0; i < 7; i++) begin
            if (offs[i] < lim) begin
                e.cyc  = base + offs[i] + ((offs[i] >= sh_from) ? sh : 0);
                e.kind = kinds[i];
                e.hs   = hss[i];
                e.clr  = (hss[i] != 2'b01);
                e.bsy  = auto_b;
                e.nin  = auto_b;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic watch(input int budget, input int pause_at, input int pause_len,
                         input int abort_at, input int rst_at, input int st_lo,
                         input int st_hi, input int mark_at, input int mark_cnt,
                         input bit use_tbl, input int auto_off);
        ev_t e;
        int  held;
        int  act_kind;
        held = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (init || out_load || done) begin
                act_kind = done ? 2 : (out_load ? 1 : 0);
                chk("strobe_onehot", int'(init) + int'(out_load) + int'(done), 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_event_cycle", k, -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_cycle", k, e.cyc);
                    chk("event_kind", act_kind, e.kind);
                    if (e.kind != 2) begin
                        chk("event_hash_select", int'(hash_select), int'(e.hs));
                        chk("event_clear", int'(clear), int'(e.clr));
                    end else begin
                        chk("done_busy", int'(busy), int'(e.bsy));
`ifdef HM_CTRL_AUTO_RESTART_EN
                        chk("done_nonce_inc", int'(nonce_inc), int'(e.nin));
`endif
                    end
                end
            end
            if (k == mark_at) begin
                chk("marked_count", int'(count), mark_cnt);
                held = int'(count);
            end
            if (pause_len > 0 && k > pause_at && k <= pause_at + pause_len) begin
                chk("paused_count_held", int'(count), held);
                chk("paused_halt", int'(halt), 1);
            end
            if (k == abort_at + 1 || k == rst_at + 1) begin
                chk("idle_outputs",
                    int'({count, halt, init, out_load, clear, busy, done, hash_select}),
                    int'({7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00}));
            end
            if (use_tbl) begin
                for (int i = 0; i < 12; i++) begin
                    if (tbl[i].k == k) begin
                        chk($sformatf("tbl%0d_ctrl", k),
                            int'({halt, init, out_load, clear, busy, hash_select}),
                            int'({tbl[i].halt, tbl[i].init, tbl[i].ld, tbl[i].clr,
                                  tbl[i].bsy, tbl[i].hs}));
                        if (tbl[i].cnt >= 0) begin
                            chk($sformatf("tbl%0d_count", k), int'(count), tbl[i].cnt);
                        end
                    end
                end
            end
            start = (k >= st_lo) && (k <= st_hi);
            pause = (k >= pause_at) && (k < pause_at + pause_len);
            abort = (k == abort_at);
            rst   = (k == rst_at);
`ifdef HM_CTRL_AUTO_RESTART_EN
            if (k == auto_off) auto_run = 1'b0;
`endif
        end
        start = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        chk("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        //        k    cnt halt init ld  clr bsy hs
        tbl[0]  = '{1,   0,  0,   1,   0,  1,  1,  2'b00};
        tbl[1]  = '{2,   0,  0,   0,   0,  1,  1,  2'b00};
        tbl[2]  = '{3,   1,  0,   0,   0,  1,  1,  2'b00};
        tbl[3]  = '{65,  63, 0,   0,   0,  1,  1,  2'b00};
        tbl[4]  = '{66,  -1, 1,   0,   1,  1,  1,  2'b00};
        tbl[5]  = '{67,  0,  0,   1,   0,  0,  1,  2'b01};
        tbl[6]  = '{100, 32, 0,   0,   0,  0,  1,  2'b01};
        tbl[7]  = '{131, 63, 0,   0,   0,  0,  1,  2'b01};
        tbl[8]  = '{133, 0,  0,   1,   0,  1,  1,  2'b10};
        tbl[9]  = '{197, 63, 0,   0,   0,  1,  1,  2'b10};
        tbl[10] = '{198, -1, 1,   0,   1,  1,  1,  2'b10};
        tbl[11] = '{200, 0,  1,   0,   0,  0,  0,  2'b00};

        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        pause = 1'b0;
`ifdef HM_CTRL_AUTO_RESTART_EN
        auto_run = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            int'({count, halt, init, out_load, clear, busy, done, hash_select}),
            int'({7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00}));
        rst = 1'b0;

        // start together with abort in IDLE must not launch a job
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", int'(busy), 0);
        chk("start_abort_init", int'(init), 0);
        @(negedge clk);
        chk("start_abort_settled", int'({busy, init, halt}), int'(3'b001));

        // nominal job: done at cycle 199
        push_job(0, 1000, 0, 1000, 1'b0);
        watch(215, -1, 0, -1, -1, -1, -1, -1, 0, 1'b1, -1);

        // pause for 5 cycles at count 20 of pass 01 shifts later events by 5
        push_job(0, 89, 5, 1000, 1'b0);
        watch(225, 88, 5, -1, -1, -1, -1, 88, 20, 1'b0, -1);

        // abort at count 40 of pass 00: only the first INIT is ever seen
        push_job(0, 1000, 0, 43, 1'b0);
        watch(215, -1, 0, 42, -1, -1, -1, 42, 40, 1'b0, -1);
        push_job(0, 1000, 0, 1000, 1'b0);
        watch(215, -1, 0, -1, -1, -1, -1, -1, 0, 1'b1, -1);

        // start held while busy, then reset in ROUND of pass 10
        push_job(0, 1000, 0, 151, 1'b0);
        watch(215, -1, 0, -1, 150, 2, 149, 150, 16, 1'b0, -1);

`ifdef HM_CTRL_AUTO_RESTART_EN
        // auto restart: second job starts right after DONE, then auto_run dropped
        auto_run = 1'b1;
        push_job(0, 1000, 0, 1000, 1'b1);
        push_job(199, 1000, 0, 1000, 1'b0);
        watch(420, -1, 0, -1, -1, -1, -1, -1, 0, 1'b0, 300);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
